// File: rtl/square.sv
`default_nettype none
// ============================================================================
// Module      : square
// Description : Sequential unsigned squarer, y = x*x, one shift-and-add step
//               per clock behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module square #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     x_bi,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam int                c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH);
    localparam logic [0:0]        c_IDLE = 1'b0;
    localparam logic [0:0]        c_WORK = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_y;
    logic                 r_done;

    logic w_last;
    logic w_accept;
    logic w_step;
    logic w_finish;

    assign w_last   = (r_cnt == c_LAST);
    assign w_accept = (r_state == c_IDLE) && start_i;
    assign w_step   = (r_state == c_WORK) && !w_last;
    assign w_finish = (r_state == c_WORK) && w_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start_i) w_state_nxt = c_WORK;
            c_WORK:  if (w_last)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == c_WORK);
    end

    // Full WIDTH iterations always run so latency never depends on the operand.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a   <= {{WIDTH{1'b0}}, x_bi};
                r_b   <= x_bi;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + c_CW'(1);
            end else if (w_finish) begin
                r_y    <= r_acc;
                r_done <= 1'b1;
            end
        end
    end

    assign done_o = r_done;
    assign y_bo   = r_y;

endmodule
`default_nettype wire

// File: tb/tb_square.sv
`default_nettype none
// ============================================================================
// Module      : tb_square
// Description : Self-checking bench for square, reference model is x*x.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_square;

    localparam int c_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_W-1:0]   x_bi = '0;
    logic             start_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [2*c_W-1:0] y_bo;

    int n_vec = 0;
    int n_bad = 0;

    square #(.WIDTH(c_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .x_bi    (x_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .y_bo    (y_bo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One pulsed job from idle; checks latency, result, done pulse width.
    task automatic run_job(input int x, input string tag);
        int lat;
        int exp;
        exp = x * x;
        x_bi    = c_W'(x);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        x_bi    = c_W'($urandom);
        lat = 0;
        while (busy_o && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, lat, c_W + 1);
        chk({tag, " done"}, {31'd0, done_o}, 1);
        chk({tag, " y"}, {16'd0, y_bo}, exp);
        @(negedge clk);
        chk({tag, " done width"}, {31'd0, done_o}, 0);
        chk({tag, " y hold"}, {16'd0, y_bo}, exp);
    endtask

    initial begin
        int k;
        int lows;
        int gap;
        int perm[256];

        // Reset and quiet idle period
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle busy", {31'd0, busy_o}, 0);
            chk("idle done", {31'd0, done_o}, 0);
            chk("idle y", {16'd0, y_bo}, 0);
        end

        run_job(13, "x13");
        run_job(0, "x0");
        run_job(1, "x1");
        run_job(255, "x255");
        run_job(128, "x128");

        // Start pulse during a job must be ignored
        x_bi = 8'd200; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        x_bi = 8'd3; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        k = 0;
        while (busy_o && k < 100) begin k++; @(negedge clk); end
        chk("midstart latency", k, c_W + 1 - 3);
        chk("midstart done", {31'd0, done_o}, 1);
        chk("midstart y", {16'd0, y_bo}, 40000);
        lows = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy_o || done_o) lows++;
        end
        chk("midstart no rerun", lows, 0);

        // Continuous start: one result every WIDTH+2 cycles
        x_bi = 8'd16; start_i = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!done_o && k < 50);
        chk("held first done", {31'd0, done_o}, 1);
        for (int j = 0; j < 3; j++) begin
            k = 0; lows = 0;
            do begin
                @(negedge clk);
                k++;
                if (!busy_o) lows++;
            end while (!done_o && k < 50);
            if (j == 2) start_i = 1'b0;
            chk("held period", k, c_W + 2);
            chk("held busy gap", lows, 1);
            chk("held y", {16'd0, y_bo}, 256);
        end
        @(negedge clk);
        chk("held stop", {31'd0, busy_o}, 0);

        // Asynchronous reset mid-job
        x_bi = 8'd99; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset busy", {31'd0, busy_o}, 0);
        chk("areset y", {16'd0, y_bo}, 0);
        chk("areset done", {31'd0, done_o}, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o || busy_o) lows++;
        end
        chk("areset no done", lows, 0);
        run_job(7, "x7");

        // Full operand sweep in shuffled order with random idle gaps
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int r, t;
            r = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[r]; perm[r] = t;
        end
        for (int i = 0; i < 256; i++) begin
            run_job(perm[i], "sweep");
            gap = int'($urandom_range(2, 0));
            repeat (gap) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square.md
# square

Sequential integer squarer: computes y = x² for an unsigned WIDTH-bit operand by shift-and-add, one partial product per clock. It is the companion of the integer square-root accelerator and uses the same start/busy handshake, so the two can be chained in either order. It sits on the same accelerator bus, for example to check root results (square(root(x)) ≤ x).

## Interface
Parameters:
- WIDTH, 8, operand width in bits; result is 2·WIDTH bits; WIDTH ≥ 2.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- x_bi  input  WIDTH  unsigned operand; sampled only on the accepting edge.
- start_i  input  1  request; accepted only while idle.
- busy_o  output  1  high while a computation is in progress.
- done_o  output  1  one-cycle pulse when y_bo has just been updated.
- y_bo  output  2·WIDTH  unsigned result x²; holds until the next completion.

## Operation
- One clock; reset is asynchronous and active-high.
- Reset forces:
  - state = IDLE, busy_o = 0, done_o = 0, y_bo = 0.
  - Internal accumulator, multiplicand, multiplier and counter all = 0.
- Registers:
  - acc (2·WIDTH bits): accumulator.
  - a (2·WIDTH bits): multiplicand, shifted left each step.
  - b (WIDTH bits): multiplier, shifted right each step.
  - cnt (clog2(WIDTH+1) bits): iteration counter.
- States: IDLE, WORK. busy_o = (state == WORK); it is a decode of the state register, not separately registered.
- IDLE:
  - start_i = 1: capture a ← zero-extended x_bi, b ← x_bi, acc ← 0, cnt ← 0, go to WORK.
  - start_i = 0: hold all registers.
- WORK, cnt < WIDTH:
  - If b[0] = 1: acc ← acc + a. The sum is truncated to 2·WIDTH bits; it cannot overflow because (2^WIDTH − 1)² < 2^(2·WIDTH).
  - a ← a << 1, b ← b >> 1, cnt ← cnt + 1.
- WORK, cnt == WIDTH: y_bo ← acc, done_o ← 1, go to IDLE.
- done_o is 0 on every other edge.
- start_i while busy_o = 1 is ignored. No queuing, and x_bi is not re-sampled.
- x_bi may change freely after the accepting edge.
- The full WIDTH iterations always run; there is no early exit for x = 0 or small x, so latency is data-independent.

## Timing
- Accepting edge E: busy_o goes high after E.
- Iteration edges: E+1 … E+WIDTH.
- Completion edge: E+WIDTH+1. On this edge y_bo updates, done_o rises for exactly one cycle, and busy_o falls.
- busy_o is high for exactly WIDTH+1 cycles (9 for WIDTH = 8).
- Back-to-back operation:
  - start_i held high across completion is not accepted on the completion edge, because the state is WORK there.
  - It is accepted on the next edge (state IDLE), so busy_o is low for exactly one cycle between jobs.
  - Throughput is one result per WIDTH+2 cycles.
- Reset asserted mid-computation:
  - Immediately aborts: busy_o = 0 and y_bo = 0 without waiting for a clock edge; done_o is not pulsed.
  - After reset deasserts, the block is idle and accepts start_i on the first edge.
- y_bo is stable at all times except on the completion edge.

## Test plan
- After reset, with no start: busy_o = 0, done_o = 0, y_bo = 0 for 20 cycles. Then x_bi = 13 with a one-cycle start_i: busy_o high for 9 cycles, y_bo = 169, and done_o pulses on the same edge that busy_o falls.
- Boundary operands, each with a one-cycle start: x = 0 → 0; x = 1 → 1; x = 255 → 65025 (16'hFE01); x = 128 → 16384. Latency is identical (9 cycles) for all four.
- Mid-job start: while busy on x = 200, change x_bi to 3 and pulse start_i. Required: y_bo = 40000, the job is not restarted, and no second busy period follows.
- start_i held high continuously with x_bi = 16: results 256 repeat every 10 cycles, with busy_o low for exactly one cycle between jobs.
- Reset mid-job: assert rst_i 4 cycles into x = 99, asynchronously to the clock. Required: busy_o and y_bo go to 0 immediately with no done_o pulse. A subsequent x = 7 gives 49.
- Sweep all 256 operands against a reference model, checking y_bo = x·x and exactly one done_o per accepted start.
